// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared trunk-mode, FSM-state and byte-enable constants for dmem_access_unit
package dmem_pkg;

    localparam logic [2:0] TRUNK_WORD   = 3'd0;
    localparam logic [2:0] TRUNK_BYTE_S = 3'd1;
    localparam logic [2:0] TRUNK_HALF_S = 3'd2;
    localparam logic [2:0] TRUNK_BYTE_U = 3'd3;
    localparam logic [2:0] TRUNK_HALF_U = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic trunk_is_byte(input logic [2:0] mode);
        return (mode == TRUNK_BYTE_S) || (mode == TRUNK_BYTE_U);
    endfunction

    function automatic logic trunk_is_half(input logic [2:0] mode);
        return (mode == TRUNK_HALF_S) || (mode == TRUNK_HALF_U);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - combinational byte/half select and sign/zero extension of a load word
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_mode,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_mode)
            TRUNK_BYTE_S: o_result = {{24{w_byte[7]}}, w_byte};
            TRUNK_HALF_S: o_result = {{16{w_half[15]}}, w_half};
            TRUNK_BYTE_U: o_result = {24'd0, w_byte};
            TRUNK_HALF_U: o_result = {16'd0, w_half};
            default:      o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage load/store unit with req/ack data memory port and pipeline stall
// Optional: DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without issuing a request.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  trunk_mode_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        err_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [2:0]  r_mode;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_start;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;
    logic        w_done;

    assign w_start = mem_read_in | mem_write_in;

    // Read wins when both strobes are set, and reads always fetch the whole word.
    always_comb begin
        w_be    = BE_WORD;
        w_wdata = wdata_in;
        if (!mem_read_in) begin
            if (trunk_is_byte(trunk_mode_in)) begin
                w_be    = BE_BYTE0 << addr_in[1:0];
                w_wdata = {4{wdata_in[7:0]}};
            end else if (trunk_is_half(trunk_mode_in)) begin
                w_be    = addr_in[1] ? BE_HALF_HI : BE_HALF_LO;
                w_wdata = {2{wdata_in[15:0]}};
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = trunk_is_half(trunk_mode_in) ? addr_in[0]
                      : (!trunk_is_byte(trunk_mode_in) && (addr_in[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= 32'd0;
            r_mode  <= TRUNK_WORD;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= addr_in;
                        r_mode  <= trunk_mode_in;
                        r_we    <= ~mem_read_in;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_rdata <= 32'd0;
                        r_cnt   <= 8'd0;
                        r_err   <= w_misalign;
                        r_state <= w_misalign ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        r_rdata <= dmem_rdata;
                        r_cnt   <= 8'd0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dmem_load_align u_load_align (
        .i_rdata   (r_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_mode    (r_mode),
        .o_result  (w_ext)
    );

    assign w_done         = (r_state == ST_DONE);
    assign stall_out      = ((r_state == ST_IDLE) && w_start) || (r_state == ST_REQ);
    assign load_valid_out = w_done && !r_we && !r_err;
    assign err_out        = w_done && r_err;
    assign load_data_out  = load_valid_out ? w_ext : 32'd0;

    assign dmem_req   = (r_state == ST_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed self-checking bench for dmem_access_unit
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  trunk_mode_in = 3'd0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        err_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    int          n_stall, n_req, n_valid, n_err, valid_cyc;
    logic [31:0] ld_data, err_data, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .trunk_mode_in(trunk_mode_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .err_out(err_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    // Presents one access for a single cycle and acks on REQ cycle ack_at (0 = never); observes 10 cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_at);
        n_stall = 0; n_req = 0; n_valid = 0; n_err = 0; valid_cyc = -1;
        ld_data = 32'hDEAD_BEEF; err_data = 32'hDEAD_BEEF;
        cap_addr = 32'hX; cap_wdata = 32'hX; cap_be = 4'hX; cap_we = 1'bX;
        @(negedge clk);
        mem_read_in = rd; mem_write_in = wr; trunk_mode_in = mode;
        addr_in = addr; wdata_in = wdata;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (stall_out) n_stall++;
            if (dmem_req) begin
                n_req++;
                if (n_req == 1) begin
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
                end
                if (n_req == ack_at) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
            end
            if (load_valid_out) begin n_valid++; ld_data = load_data_out; valid_cyc = c; end
            if (err_out) begin n_err++; err_data = load_data_out; end
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
            mem_read_in = 1'b0; mem_write_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall_out, load_valid_out, err_out, dmem_req, dmem_we} !== 5'b0 ||
            load_data_out !== 32'd0 || dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h ld=%h expected all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lb_signed;
        run_access(1'b1, 1'b0, 3'd1, 32'h0000_0103, 32'd0, 32'h80FF_1234, 2);
        checks++; if (ld_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h expected %h", ld_data, 32'hFFFF_FF80); end
        checks++; if (n_stall !== 3) begin errors++; $display("FAIL lb_stall_cycles got %0d expected 3", n_stall); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL lb_valid_pulses got %0d expected 1", n_valid); end
        checks++; if (cap_addr !== 32'h100 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
            errors++; $display("FAIL lb_bus got addr=%h be=%b we=%b expected 100 1111 0", cap_addr, cap_be, cap_we); end
    endtask

    task automatic test_lhu_zero_wait;
        run_access(1'b1, 1'b0, 3'd4, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1);
        checks++; if (ld_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_data got %h expected %h", ld_data, 32'h0000_80FF); end
        checks++; if (cap_be !== 4'b1111) begin errors++; $display("FAIL lhu_be got %b expected 1111", cap_be); end
        checks++; if (n_stall !== 2) begin errors++; $display("FAIL lhu_stall_cycles got %0d expected 2", n_stall); end
        checks++; if (valid_cyc !== 2) begin errors++; $display("FAIL lhu_valid_cycle got %0d expected 2", valid_cyc); end
    endtask

    task automatic test_other_loads;
        run_access(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'h1234_8001, 1);
        checks++; if (ld_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h expected %h", ld_data, 32'hFFFF_8001); end
        run_access(1'b1, 1'b0, 3'd3, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1);
        checks++; if (ld_data !== 32'h0000_00FF) begin errors++; $display("FAIL lbu_data got %h expected %h", ld_data, 32'h0000_00FF); end
        // Both strobes high: the read must be taken.
        run_access(1'b1, 1'b1, 3'd1, 32'h0000_0500, 32'h0000_00AB, 32'h0000_007F, 1);
        checks++; if (cap_we !== 1'b0 || cap_be !== 4'b1111 || ld_data !== 32'h0000_007F) begin
            errors++; $display("FAIL rd_wr_priority got we=%b be=%b ld=%h expected 0 1111 0000007f", cap_we, cap_be, ld_data); end
    endtask

    task automatic test_stores;
        run_access(1'b0, 1'b1, 3'd1, 32'h0000_0201, 32'h0000_00AB, 32'd0, 1);
        checks++; if (cap_be !== 4'b0010) begin errors++; $display("FAIL sb_be got %b expected 0010", cap_be); end
        checks++; if (cap_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h expected ababab ab", cap_wdata); end
        checks++; if (cap_addr !== 32'h200 || cap_we !== 1'b1) begin
            errors++; $display("FAIL sb_addr_we got %h %b expected 00000200 1", cap_addr, cap_we); end
        checks++; if (n_valid !== 0 || n_err !== 0) begin errors++; $display("FAIL sb_no_strobe got valid=%0d err=%0d expected 0 0", n_valid, n_err); end
        run_access(1'b0, 1'b1, 3'd4, 32'h0000_0402, 32'h1234_BEEF, 32'd0, 1);
        checks++; if (cap_be !== 4'b1100 || cap_wdata !== 32'hBEEF_BEEF) begin
            errors++; $display("FAIL sh_lanes got be=%b wd=%h expected 1100 beefbeef", cap_be, cap_wdata); end
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_0300, 32'd0, 32'd0, 0);
        checks++; if (n_req !== 4) begin errors++; $display("FAIL tmo_req_cycles got %0d expected 4", n_req); end
        checks++; if (n_err !== 1 || err_data !== 32'd0) begin errors++; $display("FAIL tmo_err got pulses=%0d data=%h expected 1 0", n_err, err_data); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL tmo_no_valid got %0d expected 0", n_valid); end
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        checks++; if ({load_valid_out, err_out, dmem_req, stall_out} !== 4'b0) begin
            errors++; $display("FAIL late_ack_ignored got v=%b e=%b req=%b st=%b expected 0000",
                                 load_valid_out, err_out, dmem_req, stall_out); end
    endtask

    task automatic test_align;
        run_access(1'b1, 1'b0, 3'd0, 32'h0000_0102, 32'd0, 32'hCAFE_F00D, 1);
`ifdef DMEM_ALIGN_CHECK_EN
        checks++; if (n_req !== 0 || n_stall !== 1) begin errors++; $display("FAIL align_no_req got req=%0d stall=%0d expected 0 1", n_req, n_stall); end
        checks++; if (n_err !== 1 || n_valid !== 0) begin errors++; $display("FAIL align_err got err=%0d valid=%0d expected 1 0", n_err, n_valid); end
`else
        checks++; if (cap_addr !== 32'h100) begin errors++; $display("FAIL lw_unaligned_addr got %h expected 00000100", cap_addr); end
        checks++; if (ld_data !== 32'hCAFE_F00D || n_err !== 0) begin
            errors++; $display("FAIL lw_unaligned_data got %h err=%0d expected cafef00d 0", ld_data, n_err); end
`endif
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        mem_read_in = 1'b1; trunk_mode_in = 3'd0; addr_in = 32'h0000_0700;
        @(negedge clk);
        mem_read_in = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b expected 1", dmem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req, stall_out, dmem_we, err_out, load_valid_out} !== 5'b0 ||
                      dmem_addr !== 32'd0 || dmem_be !== 4'd0 || load_data_out !== 32'd0) begin
            errors++; $display("FAIL rst_mid_outputs got req=%b st=%b addr=%h be=%b expected all zero",
                                 dmem_req, stall_out, dmem_addr, dmem_be); end
        @(negedge clk);
        rst_n = 1'b1;
        run_access(1'b0, 1'b1, 3'd0, 32'h0000_0300, 32'h1234_5678, 32'd0, 1);
        checks++; if (cap_be !== 4'b1111 || cap_wdata !== 32'h1234_5678 || cap_we !== 1'b1 || cap_addr !== 32'h300) begin
            errors++; $display("FAIL sw_after_rst got be=%b wd=%h we=%b addr=%h expected 1111 12345678 1 300",
                                 cap_be, cap_wdata, cap_we, cap_addr); end
        checks++; if (n_stall !== 2 || n_err !== 0 || n_valid !== 0) begin
            errors++; $display("FAIL sw_after_rst_ctl got stall=%0d err=%0d valid=%0d expected 2 0 0", n_stall, n_err, n_valid); end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lhu_zero_wait();
        test_other_loads();
        test_stores();
        test_timeout();
        test_align();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
